uart_cmd_responder: RTL

Byte-level command responder that sits behind the UART receiver and in front of the UART transmitter on the same (receive) clock domain. It parses host command frames from received bytes and issues register-file write/read strobes. For reads it serialises response bytes to the transmitter through its Data_Valid/busy handshake. It is the device-side end of the host command protocol carried over the UART.

---
 rtl/uart_cmd_responder_if.sv | 30 +++
 rtl/uart_cmd_responder.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_responder_if.sv
// Interface bundle for uart_cmd_responder: received bytes from the UART
// receiver, register-file write/read strobes, and the transmitter handshake.
// The slave modport is the responder's view; master is the environment's view.
interface uart_cmd_responder_if #(
   parameter int ADDR_W = 4
);
   logic [7:0]        rx_p_data;
   logic              rx_data_valid;
   logic              rx_error;
   logic [ADDR_W-1:0] rf_addr;
   logic              rf_wr_en;
   logic [7:0]        rf_wr_data;
   logic              rf_rd_en;
   logic [7:0]        rf_rd_data;
   logic              rf_rd_valid;
   logic [7:0]        tx_p_data;
   logic              tx_data_valid;
   logic              tx_busy;
   logic              cmd_error;

   modport slave (
      input  rx_p_data, rx_data_valid, rx_error, rf_rd_data, rf_rd_valid, tx_busy,
      output rf_addr, rf_wr_en, rf_wr_data, rf_rd_en, tx_p_data, tx_data_valid, cmd_error
   );

   modport master (
      output rx_p_data, rx_data_valid, rx_error, rf_rd_data, rf_rd_valid, tx_busy,
      input  rf_addr, rf_wr_en, rf_wr_data, rf_rd_en, tx_p_data, tx_data_valid, cmd_error
   );
endinterface

// File: rtl/uart_cmd_responder.sv
// uart_cmd_responder: parses host command frames (WRITE 0xAA, READ 0xBB,
// BURST 0xCC) arriving byte by byte from the UART receiver, drives register
// file strobes, and streams read data back to the UART transmitter.
// Optional inter-byte timeout: define UART_CMD_TIMEOUT_EN.
module uart_cmd_responder #(
   parameter int ADDR_W      = 4,
   parameter int TIMEOUT_CYC = 1024
) (
   input logic                  clk,
   input logic                  rst,
   uart_cmd_responder_if.slave  bus
);

   typedef enum logic [3:0] {
      S_IDLE, S_GET_ADDR, S_GET_DATA, S_GET_CNT,
      S_RD_REQ, S_RD_WAIT, S_TX_SEND, S_TX_WAIT_HI, S_TX_WAIT_LO
   } state_t;

   typedef enum logic [1:0] {
      OP_NONE, OP_WRITE, OP_READ, OP_BURST
   } opcode_t;

   state_t            state, state_d;
   opcode_t           opcode, opcode_d;
   logic [ADDR_W-1:0] addr, addr_d;
   logic [7:0]        remaining, remaining_d;
   logic [7:0]        wr_data, wr_data_d;
   logic [7:0]        tx_data, tx_data_d;
   logic              wr_en, wr_en_d;
   logic              rd_en, rd_en_d;
   logic              tx_valid, tx_valid_d;
   logic              err, err_d;
   logic              byte_ok;
   logic              byte_bad;
   logic              in_response;
   logic              tmo_hit;

   assign byte_ok     = bus.rx_data_valid && !bus.rx_error;
   assign byte_bad    = bus.rx_data_valid && bus.rx_error;
   assign in_response = (state == S_RD_REQ) || (state == S_RD_WAIT) || (state == S_TX_SEND) ||
                        (state == S_TX_WAIT_HI) || (state == S_TX_WAIT_LO);

`ifdef UART_CMD_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
   logic [TMO_W-1:0] tmo_cnt;
   logic             in_get;

   assign in_get  = (state == S_GET_ADDR) || (state == S_GET_DATA) || (state == S_GET_CNT);
   assign tmo_hit = in_get && !bus.rx_data_valid && (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));

   // Inter-byte silence counter: only runs while waiting for the rest of a
   // frame, and restarts whenever a byte arrives or the parser leaves GET_*.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tmo_cnt <= '0;
      end else if (!in_get || bus.rx_data_valid) begin
         tmo_cnt <= '0;
      end else begin
         tmo_cnt <= tmo_cnt + 1'b1;
      end
   end
`else
   assign tmo_hit = 1'b0;
`endif

   // Next-state and next-output logic. Strobes default low so every pulse is
   // exactly one cycle; data registers hold unless a state updates them.
   always_comb begin
      state_d     = state;
      opcode_d    = opcode;
      addr_d      = addr;
      remaining_d = remaining;
      wr_data_d   = wr_data;
      tx_data_d   = tx_data;
      wr_en_d     = 1'b0;
      rd_en_d     = 1'b0;
      tx_valid_d  = 1'b0;
      err_d       = 1'b0;

      case (state)
         S_IDLE: begin
            if (byte_ok) begin
               case (bus.rx_p_data)
                  8'hAA: begin opcode_d = OP_WRITE; state_d = S_GET_ADDR; end
                  8'hBB: begin opcode_d = OP_READ;  state_d = S_GET_ADDR; end
                  8'hCC: begin opcode_d = OP_BURST; state_d = S_GET_ADDR; end
                  default: err_d = 1'b1;
               endcase
            end else if (byte_bad) begin
               err_d = 1'b1;
            end
         end
         S_GET_ADDR: begin
            if (byte_bad) begin
               err_d   = 1'b1;
               state_d = S_IDLE;
            end else if (byte_ok) begin
               addr_d = bus.rx_p_data[ADDR_W-1:0];
               case (opcode)
                  OP_WRITE: state_d = S_GET_DATA;
                  OP_READ: begin
                     remaining_d = 8'd1;
                     state_d     = S_RD_REQ;
                  end
                  default: state_d = S_GET_CNT;
               endcase
            end
         end
         S_GET_DATA: begin
            if (byte_bad) begin
               err_d   = 1'b1;
               state_d = S_IDLE;
            end else if (byte_ok) begin
               wr_en_d   = 1'b1;
               wr_data_d = bus.rx_p_data;
               state_d   = S_IDLE;
            end
         end
         S_GET_CNT: begin
            if (byte_bad || (byte_ok && bus.rx_p_data == 8'd0)) begin
               err_d   = 1'b1;
               state_d = S_IDLE;
            end else if (byte_ok) begin
               remaining_d = bus.rx_p_data;
               state_d     = S_RD_REQ;
            end
         end
         S_RD_REQ: begin
            rd_en_d = 1'b1;
            state_d = S_RD_WAIT;
         end
         S_RD_WAIT: begin
            if (bus.rf_rd_valid) begin
               tx_data_d = bus.rf_rd_data;
               state_d   = S_TX_SEND;
            end
         end
         S_TX_SEND: begin
            if (!bus.tx_busy) begin
               tx_valid_d = 1'b1;
               state_d    = S_TX_WAIT_HI;
            end
         end
         S_TX_WAIT_HI: begin
            if (bus.tx_busy) begin
               state_d = S_TX_WAIT_LO;
            end
         end
         S_TX_WAIT_LO: begin
            if (!bus.tx_busy) begin
               remaining_d = remaining - 8'd1;
               addr_d      = addr + 1'b1;
               state_d     = (remaining == 8'd1) ? S_IDLE : S_RD_REQ;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (in_response && bus.rx_data_valid) begin
         err_d = 1'b1;
      end

      if (tmo_hit) begin
         err_d   = 1'b1;
         state_d = S_IDLE;
      end
   end

   // State and registered outputs; reset abandons any frame or response.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= S_IDLE;
         opcode    <= OP_NONE;
         addr      <= '0;
         remaining <= '0;
         wr_data   <= '0;
         tx_data   <= '0;
         wr_en     <= 1'b0;
         rd_en     <= 1'b0;
         tx_valid  <= 1'b0;
         err       <= 1'b0;
      end else begin
         state     <= state_d;
         opcode    <= opcode_d;
         addr      <= addr_d;
         remaining <= remaining_d;
         wr_data   <= wr_data_d;
         tx_data   <= tx_data_d;
         wr_en     <= wr_en_d;
         rd_en     <= rd_en_d;
         tx_valid  <= tx_valid_d;
         err       <= err_d;
      end
   end

   assign bus.rf_addr       = addr;
   assign bus.rf_wr_en      = wr_en;
   assign bus.rf_wr_data    = wr_data;
   assign bus.rf_rd_en      = rd_en;
   assign bus.tx_p_data     = tx_data;
   assign bus.tx_data_valid = tx_valid;
   assign bus.cmd_error     = err;

endmodule
